// File: rtl/smem_bck_issue_scheduler.sv
// Issue scheduler for the backward-extension pipeline: keeps per-read slot contexts and
// issues one {status, read_num} token per unstalled cycle, round robin over ready slots.
//
// state      | meaning
// IDLE       | slot free, may accept a new read context
// RDY_INI    | loaded, waiting for its first issue (BCK_INI)
// RDY_RUN    | returned not-done, waiting for re-issue (BCK_RUN)
// INFLT      | token travelling through the pipeline
module smem_bck_issue_scheduler #(
  parameter int READ_NUM_WIDTH = 5,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      load_valid,
  input  logic [READ_NUM_WIDTH-1:0] load_read_num,
  output logic                      load_ready,
  input  logic                      ret_valid,
  input  logic [READ_NUM_WIDTH-1:0] ret_read_num,
  input  logic                      ret_done,
  output logic [5:0]                issue_status,
  output logic [READ_NUM_WIDTH-1:0] issue_read_num,
  output logic                      done_valid,
  output logic [READ_NUM_WIDTH-1:0] done_read_num,
  output logic [CNT_WIDTH-1:0]      active_cnt,
  output logic                      err_ret
);

  localparam int RNW   = READ_NUM_WIDTH;
  localparam int NSLOT = 1 << RNW;

  // Token status codes shared with the pipeline head.
  localparam logic [5:0] BUBBLE  = 6'h00;
  localparam logic [5:0] BCK_INI = 6'h01;
  localparam logic [5:0] BCK_RUN = 6'h02;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RDY_INI = 2'd1,
    S_RDY_RUN = 2'd2,
    S_INFLT   = 2'd3
  } slot_state_t;

  slot_state_t        slot_q [NSLOT];
  logic [RNW-1:0]     rr_ptr;
  logic               sel_found;
  logic [RNW-1:0]     sel_idx;
  logic [RNW-1:0]     scan_idx;
  logic               issue_go;
  logic               load_acc;
  logic               ret_ok;
  logic               ret_fin;

  // Selection looks only at registered slot state, so a slot readied this cycle waits a cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      scan_idx = rr_ptr + RNW'(i);
      if (!sel_found && (slot_q[scan_idx] == S_RDY_INI || slot_q[scan_idx] == S_RDY_RUN)) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign load_ready = (slot_q[load_read_num] == S_IDLE);
  assign issue_go   = !stall && sel_found;
  // A return to the same slot wins over a load in the same cycle.
  assign load_acc   = load_valid && load_ready && !(ret_valid && ret_read_num == load_read_num);
  assign ret_ok     = ret_valid && (slot_q[ret_read_num] == S_INFLT);
  assign ret_fin    = ret_ok && ret_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= S_IDLE;
      rr_ptr         <= '0;
      issue_status   <= BUBBLE;
      issue_read_num <= '0;
      done_valid     <= 1'b0;
      done_read_num  <= '0;
      active_cnt     <= '0;
      err_ret        <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (ret_valid && ret_read_num == RNW'(i)) begin
          if (slot_q[i] == S_INFLT) slot_q[i] <= ret_done ? S_IDLE : S_RDY_RUN;
        end else if (load_acc && load_read_num == RNW'(i)) begin
          slot_q[i] <= S_RDY_INI;
        end else if (issue_go && sel_idx == RNW'(i)) begin
          slot_q[i] <= S_INFLT;
        end
      end

      if (!stall) begin
        if (sel_found) begin
          issue_status   <= (slot_q[sel_idx] == S_RDY_INI) ? BCK_INI : BCK_RUN;
          issue_read_num <= sel_idx;
          rr_ptr         <= sel_idx + RNW'(1);
        end else begin
          issue_status   <= BUBBLE;
          issue_read_num <= '0;
        end
      end

      done_valid <= ret_fin;
      if (ret_fin) done_read_num <= ret_read_num;

      if (load_acc && !ret_fin)      active_cnt <= active_cnt + CNT_WIDTH'(1);
      else if (!load_acc && ret_fin) active_cnt <= active_cnt - CNT_WIDTH'(1);

      if (ret_valid && !ret_ok) err_ret <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smem_bck_issue_scheduler.sv
// Bench for smem_bck_issue_scheduler: directed scenarios plus random traffic, all outputs
// compared every cycle against a slot-array reference model.
module tb_smem_bck_issue_scheduler;

  localparam int NSLOT = 32;
  localparam logic [5:0] BUBBLE  = 6'h00;
  localparam logic [5:0] BCK_INI = 6'h01;
  localparam logic [5:0] BCK_RUN = 6'h02;
  localparam int ST_IDLE = 0, ST_INI = 1, ST_RUN = 2, ST_FLY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 1'b0;
  logic       load_valid = 1'b0;
  logic [4:0] load_read_num = '0;
  logic       load_ready;
  logic       ret_valid = 1'b0;
  logic [4:0] ret_read_num = '0;
  logic       ret_done = 1'b0;
  logic [5:0] issue_status;
  logic [4:0] issue_read_num;
  logic       done_valid;
  logic [4:0] done_read_num;
  logic [5:0] active_cnt;
  logic       err_ret;

  smem_bck_issue_scheduler #(.READ_NUM_WIDTH(5), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .load_valid(load_valid), .load_read_num(load_read_num), .load_ready(load_ready),
    .ret_valid(ret_valid), .ret_read_num(ret_read_num), .ret_done(ret_done),
    .issue_status(issue_status), .issue_read_num(issue_read_num),
    .done_valid(done_valid), .done_read_num(done_read_num),
    .active_cnt(active_cnt), .err_ret(err_ret)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what each slot is waiting for, plus the expected output registers.
  int         m_st [NSLOT];
  int         m_rr;
  logic [5:0] m_status;
  int         m_num;
  bit         m_dv;
  int         m_dn;
  int         m_cnt;
  bit         m_err;

  task automatic model_step(input bit r, input bit s, input bit lv, input int ln,
                            input bit rv, input int rn, input bit rd);
    int pick;
    bit ld_ok, ret_hit, fin;
    if (!r) begin
      for (int i = 0; i < NSLOT; i++) m_st[i] = ST_IDLE;
      m_rr = 0; m_status = BUBBLE; m_num = 0; m_dv = 0; m_dn = 0; m_cnt = 0; m_err = 0;
      return;
    end
    pick = -1;
    if (!s)
      for (int i = 0; i < NSLOT; i++) begin
        int k;
        k = (m_rr + i) % NSLOT;
        if (pick < 0 && (m_st[k] == ST_INI || m_st[k] == ST_RUN)) pick = k;
      end
    ld_ok   = lv && m_st[ln] == ST_IDLE && !(rv && rn == ln);
    ret_hit = rv && m_st[rn] == ST_FLY;
    fin     = ret_hit && rd;
    if (rv && !ret_hit) m_err = 1;
    m_dv = fin;
    if (fin) m_dn = rn;
    if (ld_ok && !fin) m_cnt++;
    if (!ld_ok && fin) m_cnt--;
    if (!s) begin
      if (pick >= 0) begin
        m_status = (m_st[pick] == ST_INI) ? BCK_INI : BCK_RUN;
        m_num    = pick;
        m_rr     = (pick + 1) % NSLOT;
        m_st[pick] = ST_FLY;
      end else begin
        m_status = BUBBLE;
        m_num    = 0;
      end
    end
    if (ret_hit) m_st[rn] = rd ? ST_IDLE : ST_RUN;
    if (ld_ok) m_st[ln] = ST_INI;
  endtask

  task automatic cycle(input bit r, input bit s, input bit lv, input int ln,
                       input bit rv, input int rn, input bit rd);
    rst = r; stall = s; load_valid = lv; load_read_num = 5'(ln);
    ret_valid = rv; ret_read_num = 5'(rn); ret_done = rd;
    #1;
    check("load_ready", load_ready, m_st[ln] == ST_IDLE);
    model_step(r, s, lv, ln, rv, rn, rd);
    @(posedge clk);
    #1;
    check("issue_status", issue_status, m_status);
    check("issue_read_num", issue_read_num, m_num);
    check("done_valid", done_valid, m_dv);
    check("done_read_num", done_read_num, m_dn);
    check("active_cnt", active_cnt, m_cnt);
    check("err_ret", err_ret, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic ld(input int slot);
    cycle(1, 0, 1, slot, 0, 0, 0);
  endtask
  task automatic ret(input int slot, input bit done);
    cycle(1, 0, 0, 0, 1, slot, done);
  endtask

  initial begin
    int q[$];
    bit s, lv, rv, rd;
    int ln, rn;

    for (int i = 0; i < NSLOT; i++) m_st[i] = ST_IDLE;
    m_rr = 0; m_status = BUBBLE; m_num = 0; m_dv = 0; m_dn = 0; m_cnt = 0; m_err = 0;

    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    idle(5);
    check("idle_bubble", issue_status, BUBBLE);

    // First issue is BCK_INI, return not-done re-issues as BCK_RUN two edges later.
    ld(3);
    idle(1);
    check("ini3_status", issue_status, BCK_INI);
    check("ini3_num", issue_read_num, 3);
    idle(2);
    ret(3, 0);
    idle(1);
    check("run3_status", issue_status, BCK_RUN);
    check("run3_num", issue_read_num, 3);
    idle(1);
    ret(3, 1);
    idle(1);

    // Round robin 0,1,2 then again 0,1,2.
    ld(0); ld(1); ld(2);
    idle(1);
    ret(0, 0); ret(1, 0); ret(2, 0);
    check("rr_third", issue_read_num, 1);
    idle(1);
    check("rr_last", issue_read_num, 2);
    ret(0, 1); ret(1, 1); ret(2, 1);
    idle(1);

    // rr_ptr at 31 with 31 and 0 ready: 31 goes first, then wraps to 0.
    ld(30);
    idle(1);
    cycle(1, 1, 1, 31, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    idle(1);
    check("wrap_first", issue_read_num, 31);
    idle(1);
    check("wrap_second", issue_read_num, 0);
    ret(30, 1); ret(31, 1); ret(0, 1);
    idle(1);

    // Stall with a done return and a fresh load in the shadow.
    ld(1);
    idle(1);
    cycle(1, 1, 0, 0, 1, 1, 1);
    check("stall_done_pulse", done_valid, 1);
    check("stall_done_num", done_read_num, 1);
    cycle(1, 1, 1, 4, 0, 0, 0);
    check("stall_pulse_once", done_valid, 0);
    check("stall_frozen", issue_read_num, 1);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    idle(1);
    check("after_stall", issue_read_num, 4);
    idle(3);
    ret(4, 1);
    idle(1);

    // Load to an in-flight slot is refused; return to an idle slot is an error.
    ld(5);
    idle(1);
    cycle(1, 0, 1, 5, 0, 0, 0);
    check("busy_load_ready", load_ready, 0);
    check("busy_cnt", active_cnt, 1);
    check("no_err_yet", err_ret, 0);
    ret(7, 0);
    idle(3);
    check("err_sticky", err_ret, 1);
    ret(5, 1);
    idle(1);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      q.delete();
      for (int i = 0; i < NSLOT; i++) if (m_st[i] == ST_FLY) q.push_back(i);
      s  = ($urandom % 5) == 0;
      lv = ($urandom % 2) == 0;
      ln = $urandom % NSLOT;
      rv = 0; rn = 0; rd = 0;
      if (q.size() > 0 && ($urandom % 3) != 0) begin
        rv = 1;
        rn = q[$urandom % q.size()];
        rd = ($urandom % 3) == 0;
      end else if (($urandom % 40) == 0) begin
        rv = 1;
        rn = $urandom % NSLOT;
      end
      if (lv && rv && ln == rn) lv = 0;
      cycle(1, s, lv, ln, rv, rn, rd);
    end

    // Reset with several reads in flight discards everything.
    for (int i = 10; i < 14; i++) ld(i);
    idle(4);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("rst_bubble", issue_status, BUBBLE);
    check("rst_cnt", active_cnt, 0);
    check("rst_err", err_ret, 0);
    for (int i = 0; i < NSLOT; i++) begin
      load_read_num = 5'(i);
      #1;
      check("rst_load_ready", load_ready, 1);
    end
    ret(11, 0);
    check("late_ret_err", err_ret, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
